alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_seq_ctrl_if.sv | 26 ++
 rtl/alu_seq_ctrl.sv | 110 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for alu_seq_ctrl (default width, opcodes, external ALU encodings, FSM state enum)
package alu_seq_pkg;
    localparam int ALU_WIDTH = 16;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;
    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_e;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: bundle of cmd_*/rsp_* handshake and alu_* drive/return; slave = controller view, master = host+ALU view
interface alu_seq_ctrl_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             cmd_valid, cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero, rsp_carry, rsp_err;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [1:0]       alu_op;
    logic             alu_ainvert, alu_bnegate, alu_carry;
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_result, alu_carry,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err,
               alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate
    );
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, alu_result, alu_carry,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_err,
               alu_a, alu_b, alu_op, alu_ainvert, alu_bnegate
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences commands onto an external ALU (clk, sync active-low rst_n, bus = alu_seq_ctrl_if.slave); shift-add MUL only when ALU_SEQ_MUL_EN is defined
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter int MUL_ITER = WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    alu_seq_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = S_IDLE;
    localparam logic [1:0] EXEC = S_EXEC;
    localparam logic [1:0] RESP = S_RESP;
    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q, err_q, slt_bit;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] MUL = S_MUL;
    localparam int CW = $clog2(MUL_ITER + 1);
    logic [CW-1:0] cnt;
    logic          lost;
`endif
    // signed less-than: sign of A-B corrected by two's-complement overflow
    assign slt_bit = bus.alu_result[WIDTH-1] ^ ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (bus.alu_result[WIDTH-1] ^ a_q[WIDTH-1]));
    assign bus.cmd_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_data  = res_q;
    assign bus.rsp_zero  = ~|res_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_err   = err_q;
    always_comb begin
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_op      = ALU_AND;
        bus.alu_ainvert = 1'b0;
        bus.alu_bnegate = 1'b0;
        if (state == EXEC) begin
            bus.alu_a       = a_q;
            bus.alu_b       = b_q;
            bus.alu_op      = (op_q == OP_AND || op_q == OP_NOR) ? ALU_AND : (op_q == OP_OR) ? ALU_OR : ALU_ADD;
            bus.alu_ainvert = op_q == OP_NOR;
            bus.alu_bnegate = op_q == OP_SUB || op_q == OP_SLT || op_q == OP_NOR;
        end
`ifdef ALU_SEQ_MUL_EN
        if (state == MUL) begin
            bus.alu_a  = res_q;
            bus.alu_b  = a_q;
            bus.alu_op = ALU_ADD;
        end
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt     <= '0;
            lost    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    op_q    <= bus.cmd_op;
                    a_q     <= bus.cmd_a;
                    b_q     <= bus.cmd_b;
                    res_q   <= '0;
                    carry_q <= 1'b0;
                    err_q   <= bus.cmd_op > OP_NOR;
                    state   <= (bus.cmd_op > OP_NOR) ? RESP : EXEC;
`ifdef ALU_SEQ_MUL_EN
                    cnt     <= '0;
                    lost    <= 1'b0;
                    if (bus.cmd_op == OP_MUL) begin
                        err_q <= 1'b0;
                        state <= MUL;
                    end
`endif
                end
                EXEC: begin
                    res_q   <= (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : bus.alu_result;
                    carry_q <= bus.alu_carry;
                    state   <= RESP;
                end
`ifdef ALU_SEQ_MUL_EN
                // lost remembers a set bit shifted out of the multiplicand; adding while it is set means the true product exceeds WIDTH
                MUL: begin
                    if (b_q[0]) begin
                        res_q   <= bus.alu_result;
                        carry_q <= carry_q | bus.alu_carry | lost;
                    end
                    lost  <= lost | a_q[WIDTH-1];
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + CW'(1);
                    state <= (cnt == CW'(MUL_ITER - 1)) ? RESP : MUL;
                end
`endif
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed bench for alu_seq_ctrl with a behavioural external ALU; MUL vectors when ALU_SEQ_MUL_EN is defined
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    alu_seq_ctrl_if bus ();
    alu_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    logic [15:0] ax, by;
    logic [16:0] sum;
    assign ax = bus.alu_ainvert ? ~bus.alu_a : bus.alu_a;
    assign by = bus.alu_bnegate ? ~bus.alu_b : bus.alu_b;
    assign sum = {1'b0, ax} + {1'b0, by} + 17'(bus.alu_bnegate);
    assign bus.alu_result = (bus.alu_op == 2'b00) ? (ax & by) : (bus.alu_op == 2'b01) ? (ax | by) : sum[15:0];
    assign bus.alu_carry = sum[16];
    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask
    task automatic idle_outputs(input string tag);
        chk(tag, "cmd_ready", 32'(bus.cmd_ready), 1);
        chk(tag, "rsp_valid", 32'(bus.rsp_valid), 0);
        chk(tag, "rsp_data", 32'(bus.rsp_data), 0);
        chk(tag, "rsp_carry_err", {30'd0, bus.rsp_carry, bus.rsp_err}, 0);
        chk(tag, "alu_drive", {bus.alu_a, bus.alu_b} | 32'({bus.alu_op, bus.alu_ainvert, bus.alu_bnegate}), 0);
    endtask
    task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input logic [15:0] d, input logic z, input logic c, input logic e,
                         input bit ck_c, input int hold);
        int n;
        @(negedge clk);
        chk(tag, "cmd_ready", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < lat + 4) begin
            @(negedge clk);
            n++;
        end
        chk(tag, "latency", 32'(n), 32'(lat));
        chk(tag, "rsp_data", 32'(bus.rsp_data), 32'(d));
        chk(tag, "rsp_zero", 32'(bus.rsp_zero), 32'(z));
        chk(tag, "rsp_err", 32'(bus.rsp_err), 32'(e));
        if (ck_c) chk(tag, "rsp_carry", 32'(bus.rsp_carry), 32'(c));
        chk(tag, "alu_in_resp", {bus.alu_a, bus.alu_b}, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk(tag, "hold_valid", 32'(bus.rsp_valid), 1);
            chk(tag, "hold_data", 32'(bus.rsp_data), 32'(d));
            chk(tag, "hold_cmd_ready", 32'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk(tag, "back_idle", {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'b10);
    endtask
    task automatic abort_after(input string tag, input logic [2:0] op, input int cycles);
        bit seen;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = 16'h0012;
        bus.cmd_b = 16'h0034;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 1; i < cycles; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        idle_outputs(tag);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid;
        end
        chk(tag, "no_rsp_pulse", 32'(seen), 0);
    endtask
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        idle_outputs("reset");
        rst_n = 1'b1;
        do_op("add", 3'd2, 16'h7FFF, 16'h0001, 2, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        do_op("sub", 3'd3, 16'h1234, 16'h1234, 2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        do_op("slt_true", 3'd4, 16'h8000, 16'h0001, 2, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        do_op("slt_false", 3'd4, 16'h0001, 16'h8000, 2, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        do_op("and", 3'd0, 16'hF0F0, 16'hFF00, 2, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_op("or", 3'd1, 16'h00F0, 16'h0F00, 2, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_op("nor_hold", 3'd5, 16'h00FF, 16'h0F00, 2, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        do_op("illegal", 3'd7, 16'h1111, 16'h2222, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 0);
`ifdef ALU_SEQ_MUL_EN
        do_op("mul_small", 3'd6, 16'h0012, 16'h0034, 17, 16'h03A8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        do_op("mul_ovf", 3'd6, 16'h0100, 16'h0100, 17, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        do_op("mul_max", 3'd6, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        do_op("mul_zero", 3'd6, 16'h0000, 16'hABCD, 17, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        abort_after("abort_mul", 3'd6, 8);
`else
        do_op("mul_disabled", 3'd6, 16'h0012, 16'h0034, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 0);
`endif
        abort_after("abort_exec", 3'd2, 1);
        do_op("add_wrap", 3'd2, 16'hFFFF, 16'h0001, 2, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
